// File: rtl/rob_pkg.sv
// Shared definitions for the parametrised re-order buffer: tag sizing,
// the "no producer" tag and the per-entry status flag layout.
package rob_pkg;

    localparam int TAG_NONE = 0;

    // Tags are entry index + 1, so one extra bit keeps 0 free for "no producer".
    function automatic int tag_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic busy;
        logic ready;
        logic is_branch;
        logic is_store;
        logic io;
        logic pred;
        logic taken;
    } rob_flags_t;

endpackage

// File: rtl/rob_param_if.sv
// Bus bundle between the ROB and its dispatcher, operand readers,
// writeback units and retire consumers.
interface rob_param_if #(
    parameter int NUM_WB = 2,
    parameter int XLEN   = 32,
    parameter int IDW    = 5
);
    // Dispatch handshake: an instruction transfers on a rising clk edge where
    // disp_valid_in && disp_ready_out; ready depends only on registered state.
    logic                   disp_valid_in;
    logic                   disp_ready_out;
    logic [IDW-1:0]         disp_id_out;
    logic [4:0]             disp_rd_in;
    logic [XLEN-1:0]        disp_pc_in;
    logic [XLEN-1:0]        disp_rollback_pc_in;
    logic                   disp_is_branch_in;
    logic                   disp_is_store_in;
    logic                   disp_pred_taken_in;
    logic [IDW-1:0]         q1_in;
    logic [IDW-1:0]         q2_in;
    logic                   q1_ready_out;
    logic                   q2_ready_out;
    logic [XLEN-1:0]        q1_data_out;
    logic [XLEN-1:0]        q2_data_out;
    logic [NUM_WB-1:0]      wb_valid_in;
    logic [NUM_WB*IDW-1:0]  wb_id_in;
    logic [NUM_WB*XLEN-1:0] wb_data_in;
    logic [NUM_WB*XLEN-1:0] wb_target_in;
    logic [NUM_WB-1:0]      wb_taken_in;
    logic                   commit_valid_out;
    logic [IDW-1:0]         commit_id_out;
    logic [4:0]             commit_rd_out;
    logic [XLEN-1:0]        commit_data_out;
    logic                   commit_is_store_out;
    logic                   bp_update_out;
    logic                   bp_taken_out;
    logic [XLEN-1:0]        bp_pc_out;
    logic                   flush_out;
    logic [XLEN-1:0]        flush_pc_out;

    modport master (
        output disp_valid_in, disp_rd_in, disp_pc_in, disp_rollback_pc_in,
               disp_is_branch_in, disp_is_store_in, disp_pred_taken_in,
               q1_in, q2_in, wb_valid_in, wb_id_in, wb_data_in, wb_target_in, wb_taken_in,
        input  disp_ready_out, disp_id_out, q1_ready_out, q2_ready_out, q1_data_out, q2_data_out,
               commit_valid_out, commit_id_out, commit_rd_out, commit_data_out, commit_is_store_out,
               bp_update_out, bp_taken_out, bp_pc_out, flush_out, flush_pc_out
    );

    modport slave (
        input  disp_valid_in, disp_rd_in, disp_pc_in, disp_rollback_pc_in,
               disp_is_branch_in, disp_is_store_in, disp_pred_taken_in,
               q1_in, q2_in, wb_valid_in, wb_id_in, wb_data_in, wb_target_in, wb_taken_in,
        output disp_ready_out, disp_id_out, q1_ready_out, q2_ready_out, q1_data_out, q2_data_out,
               commit_valid_out, commit_id_out, commit_rd_out, commit_data_out, commit_is_store_out,
               bp_update_out, bp_taken_out, bp_pc_out, flush_out, flush_pc_out
    );
endinterface

// File: rtl/rob_wb_match.sv
// Finds a tag among the writeback channels; the highest-index matching
// channel supplies the data. Tag 0 never matches.
module rob_wb_match import rob_pkg::*; #(
    parameter int NUM_WB = 2,
    parameter int IDW    = 5,
    parameter int DW     = 32
) (
    input  logic [IDW-1:0]        tag_i,
    input  logic [NUM_WB-1:0]     wb_valid_i,
    input  logic [NUM_WB*IDW-1:0] wb_id_i,
    input  logic [NUM_WB*DW-1:0]  wb_data_i,
    output logic                  hit_o,
    output logic [DW-1:0]         data_o
);
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int c = 0; c < NUM_WB; c++) begin
            if (wb_valid_i[c] && (tag_i != IDW'(TAG_NONE)) && (wb_id_i[c*IDW +: IDW] == tag_i)) begin
                hit_o  = 1'b1;
                data_o = wb_data_i[c*DW +: DW];
            end
        end
    end
endmodule

// File: rtl/rob_param.sv
// Circular re-order buffer: in-order dispatch and retire, NUM_WB writeback
// channels with operand bypass, registered branch-mispredict flush.
module rob_param import rob_pkg::*; #(
    parameter int DEPTH  = 16,
    parameter int NUM_WB = 2,
    parameter int XLEN   = 32,
    parameter int IDW    = tag_width(DEPTH)
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    rob_param_if.slave     bus,
    input  logic [IDW-1:0] io_id_in,
    output logic [IDW-1:0] head_io_id_out,
    output logic [IDW-1:0] count_out
);
    localparam int AW  = $clog2(DEPTH);
    localparam int WBW = 2 * XLEN + 1;

    rob_flags_t      flags_q  [DEPTH], flags_d  [DEPTH];
    logic [XLEN-1:0] data_q   [DEPTH], data_d   [DEPTH];
    logic [XLEN-1:0] target_q [DEPTH], target_d [DEPTH];
    logic [XLEN-1:0] pc_q     [DEPTH], pc_d     [DEPTH];
    logic [XLEN-1:0] rbpc_q   [DEPTH], rbpc_d   [DEPTH];
    logic [4:0]      rd_q     [DEPTH], rd_d     [DEPTH];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [IDW-1:0]  count_q, count_d;

    logic            commit_valid_q, commit_valid_d, commit_is_store_q, commit_is_store_d;
    logic [IDW-1:0]  commit_id_q, commit_id_d;
    logic [4:0]      commit_rd_q, commit_rd_d;
    logic [XLEN-1:0] commit_data_q, commit_data_d, bp_pc_q, bp_pc_d, flush_pc_q, flush_pc_d;
    logic            bp_update_q, bp_update_d, bp_taken_q, bp_taken_d, flush_q, flush_d;

    logic [NUM_WB*WBW-1:0] wb_bundle;
    logic                  ent_hit [DEPTH];
    logic [WBW-1:0]        ent_wb  [DEPTH];
    logic                  q1_hit, q2_hit, do_disp, do_commit;
    logic [XLEN-1:0]       q1_wb, q2_wb;
    logic [AW-1:0]         q1_idx, q2_idx;

    // Per-entry match carries {taken, target, data} so one matcher covers all three fields.
    always_comb begin
        wb_bundle = '0;
        for (int c = 0; c < NUM_WB; c++) begin
            wb_bundle[c*WBW +: WBW] = {bus.wb_taken_in[c], bus.wb_target_in[c*XLEN +: XLEN],
                                       bus.wb_data_in[c*XLEN +: XLEN]};
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        rob_wb_match #(.NUM_WB(NUM_WB), .IDW(IDW), .DW(WBW)) u_match (
            .tag_i(IDW'(k + 1)), .wb_valid_i(bus.wb_valid_in), .wb_id_i(bus.wb_id_in),
            .wb_data_i(wb_bundle), .hit_o(ent_hit[k]), .data_o(ent_wb[k])
        );
    end

    rob_wb_match #(.NUM_WB(NUM_WB), .IDW(IDW), .DW(XLEN)) u_q1 (
        .tag_i(bus.q1_in), .wb_valid_i(bus.wb_valid_in), .wb_id_i(bus.wb_id_in),
        .wb_data_i(bus.wb_data_in), .hit_o(q1_hit), .data_o(q1_wb)
    );
    rob_wb_match #(.NUM_WB(NUM_WB), .IDW(IDW), .DW(XLEN)) u_q2 (
        .tag_i(bus.q2_in), .wb_valid_i(bus.wb_valid_in), .wb_id_i(bus.wb_id_in),
        .wb_data_i(bus.wb_data_in), .hit_o(q2_hit), .data_o(q2_wb)
    );

    assign bus.disp_ready_out = (count_q < IDW'(DEPTH)) && !flush_q;
    assign bus.disp_id_out    = IDW'(tail_q) + IDW'(1);
    assign do_disp            = bus.disp_valid_in && bus.disp_ready_out;
    assign do_commit          = flags_q[head_q].busy && (flags_q[head_q].ready || flags_q[head_q].is_store);
    assign head_io_id_out     = (flags_q[head_q].busy && flags_q[head_q].io) ? IDW'(head_q) + IDW'(1) : '0;
    assign count_out          = count_q;

    always_comb begin
        q1_idx           = AW'(bus.q1_in - IDW'(1));
        q2_idx           = AW'(bus.q2_in - IDW'(1));
        bus.q1_ready_out = 1'b0;
        bus.q1_data_out  = '0;
        bus.q2_ready_out = 1'b0;
        bus.q2_data_out  = '0;
        if (bus.q1_in != IDW'(TAG_NONE)) begin
            bus.q1_ready_out = flags_q[q1_idx].ready || q1_hit;
            bus.q1_data_out  = q1_hit ? q1_wb : data_q[q1_idx];
        end
        if (bus.q2_in != IDW'(TAG_NONE)) begin
            bus.q2_ready_out = flags_q[q2_idx].ready || q2_hit;
            bus.q2_data_out  = q2_hit ? q2_wb : data_q[q2_idx];
        end
    end

    always_comb begin
        flags_d = flags_q;  data_d = data_q;  target_d = target_q;
        pc_d    = pc_q;     rbpc_d = rbpc_q;  rd_d     = rd_q;
        head_d  = head_q;   tail_d = tail_q;  count_d  = count_q;
        commit_valid_d = commit_valid_q;  commit_id_d = commit_id_q;  commit_rd_d = commit_rd_q;
        commit_data_d  = commit_data_q;   commit_is_store_d = commit_is_store_q;
        bp_update_d    = bp_update_q;     bp_taken_d  = bp_taken_q;   bp_pc_d     = bp_pc_q;
        flush_d        = flush_q;         flush_pc_d  = flush_pc_q;
        if (rdy_in && flush_q) begin
            for (int k = 0; k < DEPTH; k++) begin
                flags_d[k] = '0; data_d[k] = '0; target_d[k] = '0;
                pc_d[k]    = '0; rbpc_d[k] = '0; rd_d[k]     = '0;
            end
            head_d = '0; tail_d = '0; count_d = '0;
            commit_valid_d = 1'b0; bp_update_d = 1'b0; flush_d = 1'b0;
        end else if (rdy_in) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (ent_hit[k] && flags_q[k].busy) begin
                    flags_d[k].ready = 1'b1;
                    flags_d[k].taken = ent_wb[k][2*XLEN];
                    target_d[k]      = ent_wb[k][2*XLEN-1:XLEN];
                    data_d[k]        = ent_wb[k][XLEN-1:0];
                end
                if ((io_id_in == IDW'(k + 1)) && flags_q[k].busy) flags_d[k].io = 1'b1;
            end
            // Commit decisions use only registered head state; same-cycle writebacks wait a cycle.
            commit_valid_d = do_commit;
            bp_update_d    = do_commit && flags_q[head_q].is_branch;
            flush_d        = do_commit && flags_q[head_q].is_branch && (flags_q[head_q].taken != flags_q[head_q].pred);
            if (do_commit) begin
                commit_id_d       = IDW'(head_q) + IDW'(1);
                commit_rd_d       = rd_q[head_q];
                commit_data_d     = data_q[head_q];
                commit_is_store_d = flags_q[head_q].is_store;
                if (flags_q[head_q].is_branch) begin
                    bp_pc_d    = pc_q[head_q];
                    bp_taken_d = flags_q[head_q].taken;
                    if (flags_q[head_q].taken != flags_q[head_q].pred)
                        flush_pc_d = flags_q[head_q].taken ? target_q[head_q] : rbpc_q[head_q];
                end
                flags_d[head_q] = '0; data_d[head_q] = '0; target_d[head_q] = '0;
                head_d = head_q + AW'(1);
            end
            if (do_disp) begin
                flags_d[tail_q]           = '0;
                flags_d[tail_q].busy      = 1'b1;
                flags_d[tail_q].is_branch = bus.disp_is_branch_in;
                flags_d[tail_q].is_store  = bus.disp_is_store_in;
                flags_d[tail_q].pred      = bus.disp_pred_taken_in;
                data_d[tail_q] = '0;                    target_d[tail_q] = '0;
                pc_d[tail_q]   = bus.disp_pc_in;        rbpc_d[tail_q]   = bus.disp_rollback_pc_in;
                rd_d[tail_q]   = bus.disp_rd_in;
                tail_d = tail_q + AW'(1);
            end
            if (do_disp && !do_commit)      count_d = count_q + IDW'(1);
            else if (!do_disp && do_commit) count_d = count_q - IDW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int k = 0; k < DEPTH; k++) begin
                flags_q[k] <= '0; data_q[k] <= '0; target_q[k] <= '0;
                pc_q[k]    <= '0; rbpc_q[k] <= '0; rd_q[k]     <= '0;
            end
            head_q <= '0; tail_q <= '0; count_q <= '0;
            commit_valid_q <= 1'b0; commit_id_q <= '0; commit_rd_q <= '0;
            commit_data_q  <= '0;   commit_is_store_q <= 1'b0;
            bp_update_q <= 1'b0; bp_taken_q <= 1'b0; bp_pc_q <= '0;
            flush_q     <= 1'b0; flush_pc_q <= '0;
        end else begin
            flags_q <= flags_d; data_q <= data_d; target_q <= target_d;
            pc_q    <= pc_d;    rbpc_q <= rbpc_d; rd_q     <= rd_d;
            head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
            commit_valid_q <= commit_valid_d; commit_id_q <= commit_id_d; commit_rd_q <= commit_rd_d;
            commit_data_q  <= commit_data_d;  commit_is_store_q <= commit_is_store_d;
            bp_update_q <= bp_update_d; bp_taken_q <= bp_taken_d; bp_pc_q <= bp_pc_d;
            flush_q     <= flush_d;     flush_pc_q <= flush_pc_d;
        end
    end

    assign bus.commit_valid_out    = commit_valid_q;
    assign bus.commit_id_out       = commit_id_q;
    assign bus.commit_rd_out       = commit_rd_q;
    assign bus.commit_data_out     = commit_data_q;
    assign bus.commit_is_store_out = commit_is_store_q;
    assign bus.bp_update_out       = bp_update_q;
    assign bus.bp_taken_out        = bp_taken_q;
    assign bus.bp_pc_out           = bp_pc_q;
    assign bus.flush_out           = flush_q;
    assign bus.flush_pc_out        = flush_pc_q;
endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param (DEPTH=8): in-order retire, full/wrap,
// branch flush, store/IO, writeback bypass, freeze and async reset.
module tb_rob_param;
    localparam int DEPTH  = 8;
    localparam int NUM_WB = 2;
    localparam int XLEN   = 32;
    localparam int IDW    = 4;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           rdy_in;
    logic [IDW-1:0] io_id_in;
    logic [IDW-1:0] head_io_id_out;
    logic [IDW-1:0] count_out;
    int             n_checks = 0;
    int             n_fail   = 0;

    rob_param_if #(.NUM_WB(NUM_WB), .XLEN(XLEN), .IDW(IDW)) bus ();

    rob_param #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .XLEN(XLEN), .IDW(IDW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus),
        .io_id_in(io_id_in), .head_io_id_out(head_io_id_out), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wb_clear();
        bus.wb_valid_in = '0; bus.wb_id_in = '0; bus.wb_data_in = '0;
        bus.wb_target_in = '0; bus.wb_taken_in = '0;
    endtask

    task automatic drive_idle();
        bus.disp_valid_in = 1'b0; bus.disp_rd_in = '0; bus.disp_pc_in = '0;
        bus.disp_rollback_pc_in = '0; bus.disp_is_branch_in = 1'b0;
        bus.disp_is_store_in = 1'b0; bus.disp_pred_taken_in = 1'b0;
        bus.q1_in = '0; bus.q2_in = '0; io_id_in = '0;
        wb_clear();
    endtask

    task automatic apply_reset();
        rst_in = 1'b0; rdy_in = 1'b1; drive_idle();
        step(); step();
        rst_in = 1'b1;
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] rb,
                            input logic br, input logic st, input logic pred);
        bus.disp_valid_in = 1'b1; bus.disp_rd_in = rd; bus.disp_pc_in = pc;
        bus.disp_rollback_pc_in = rb; bus.disp_is_branch_in = br;
        bus.disp_is_store_in = st; bus.disp_pred_taken_in = pred;
        step();
        bus.disp_valid_in = 1'b0;
    endtask

    task automatic wb_set(input int ch, input logic [IDW-1:0] tag, input logic [31:0] data,
                          input logic [31:0] target, input logic taken);
        bus.wb_valid_in[ch] = 1'b1;
        bus.wb_id_in[ch*IDW +: IDW] = tag;
        bus.wb_data_in[ch*XLEN +: XLEN] = data;
        bus.wb_target_in[ch*XLEN +: XLEN] = target;
        bus.wb_taken_in[ch] = taken;
    endtask

    task automatic writeback(input int ch, input logic [IDW-1:0] tag, input logic [31:0] data,
                             input logic [31:0] target, input logic taken);
        wb_set(ch, tag, data, target, taken);
        step();
        wb_clear();
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; drive_idle();
        #1 rst_in = 1'b0;
        #2;
        n_checks++; if (count_out !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count_out); end
        n_checks++; if (bus.disp_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.disp_ready_out); end
        n_checks++; if (bus.disp_id_out !== 4'd1) begin n_fail++; $display("FAIL reset_disp_id got=%0d exp=1", bus.disp_id_out); end
        n_checks++; if (bus.commit_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_commit got=%b exp=0", bus.commit_valid_out); end
        n_checks++; if (bus.flush_out !== 1'b0 || bus.bp_update_out !== 1'b0) begin n_fail++; $display("FAIL reset_flush_bp got=%b%b exp=00", bus.flush_out, bus.bp_update_out); end
        n_checks++; if (head_io_id_out !== 4'd0) begin n_fail++; $display("FAIL reset_head_io got=%0d exp=0", head_io_id_out); end
        step(); step();
        rst_in = 1'b1;
    endtask

    task automatic test_in_order();
        apply_reset();
        dispatch(5'd1, 32'h10, 32'h14, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.disp_id_out !== 4'd2) begin n_fail++; $display("FAIL order_disp_id2 got=%0d exp=2", bus.disp_id_out); end
        dispatch(5'd2, 32'h14, 32'h18, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.disp_id_out !== 4'd3) begin n_fail++; $display("FAIL order_disp_id3 got=%0d exp=3", bus.disp_id_out); end
        dispatch(5'd3, 32'h18, 32'h1c, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count_out !== 4'd3) begin n_fail++; $display("FAIL order_count3 got=%0d exp=3", count_out); end
        writeback(0, 4'd2, 32'h22, 32'h0, 1'b0);
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b0) begin n_fail++; $display("FAIL order_no_early_commit got=%b exp=0", bus.commit_valid_out); end
        writeback(0, 4'd1, 32'h11, 32'h0, 1'b0);
        n_checks++; if (bus.commit_valid_out !== 1'b0) begin n_fail++; $display("FAIL order_wb_latency got=%b exp=0", bus.commit_valid_out); end
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b1 || bus.commit_id_out !== 4'd1 || bus.commit_rd_out !== 5'd1 || bus.commit_data_out !== 32'h11)
            begin n_fail++; $display("FAIL order_commit1 got=v%b id%0d rd%0d d%0h exp=v1 id1 rd1 d11", bus.commit_valid_out, bus.commit_id_out, bus.commit_rd_out, bus.commit_data_out); end
        n_checks++; if (count_out !== 4'd2) begin n_fail++; $display("FAIL order_count2 got=%0d exp=2", count_out); end
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b1 || bus.commit_id_out !== 4'd2 || bus.commit_data_out !== 32'h22)
            begin n_fail++; $display("FAIL order_commit2 got=v%b id%0d d%0h exp=v1 id2 d22", bus.commit_valid_out, bus.commit_id_out, bus.commit_data_out); end
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b0 || count_out !== 4'd1) begin n_fail++; $display("FAIL order_hold3 got=v%b c%0d exp=v0 c1", bus.commit_valid_out, count_out); end
        writeback(1, 4'd3, 32'h33, 32'h0, 1'b0);
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b1 || bus.commit_id_out !== 4'd3 || bus.commit_data_out !== 32'h33 || bus.commit_is_store_out !== 1'b0)
            begin n_fail++; $display("FAIL order_commit3 got=v%b id%0d d%0h s%b exp=v1 id3 d33 s0", bus.commit_valid_out, bus.commit_id_out, bus.commit_data_out, bus.commit_is_store_out); end
        n_checks++; if (count_out !== 4'd0) begin n_fail++; $display("FAIL order_count0 got=%0d exp=0", count_out); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) dispatch(5'(i + 1), 32'(i * 4), 32'(i * 4 + 4), 1'b0, 1'b0, 1'b0);
        n_checks++; if (count_out !== 4'd8 || bus.disp_ready_out !== 1'b0) begin n_fail++; $display("FAIL full_state got=c%0d r%b exp=c8 r0", count_out, bus.disp_ready_out); end
        n_checks++; if (bus.disp_id_out !== 4'd1) begin n_fail++; $display("FAIL full_wrap_id got=%0d exp=1", bus.disp_id_out); end
        dispatch(5'd9, 32'h900, 32'h904, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count_out !== 4'd8) begin n_fail++; $display("FAIL full_drop got=%0d exp=8", count_out); end
        writeback(0, 4'd1, 32'h55, 32'h0, 1'b0);
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b1 || bus.commit_id_out !== 4'd1 || bus.commit_rd_out !== 5'd1 || bus.commit_data_out !== 32'h55)
            begin n_fail++; $display("FAIL full_commit got=v%b id%0d rd%0d d%0h exp=v1 id1 rd1 d55", bus.commit_valid_out, bus.commit_id_out, bus.commit_rd_out, bus.commit_data_out); end
        n_checks++; if (count_out !== 4'd7 || bus.disp_ready_out !== 1'b1 || bus.disp_id_out !== 4'd1)
            begin n_fail++; $display("FAIL full_free got=c%0d r%b id%0d exp=c7 r1 id1", count_out, bus.disp_ready_out, bus.disp_id_out); end
        dispatch(5'd10, 32'h40, 32'h44, 1'b0, 1'b0, 1'b0);
        bus.q1_in = 4'd1;
        #1;
        n_checks++; if (count_out !== 4'd8 || bus.disp_id_out !== 4'd2 || bus.q1_ready_out !== 1'b0)
            begin n_fail++; $display("FAIL full_reuse got=c%0d id%0d q1r%b exp=c8 id2 q1r0", count_out, bus.disp_id_out, bus.q1_ready_out); end
        bus.q1_in = '0;
    endtask

    task automatic test_branch();
        apply_reset();
        dispatch(5'd0, 32'h40, 32'h44, 1'b1, 1'b0, 1'b0);
        dispatch(5'd5, 32'h44, 32'h48, 1'b0, 1'b0, 1'b0);
        writeback(0, 4'd1, 32'h0, 32'h100, 1'b1);
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b1 || bus.bp_update_out !== 1'b1 || bus.bp_taken_out !== 1'b1 || bus.bp_pc_out !== 32'h40)
            begin n_fail++; $display("FAIL br_bp got=v%b u%b t%b pc%0h exp=v1 u1 t1 pc40", bus.commit_valid_out, bus.bp_update_out, bus.bp_taken_out, bus.bp_pc_out); end
        n_checks++; if (bus.flush_out !== 1'b1 || bus.flush_pc_out !== 32'h100 || bus.disp_ready_out !== 1'b0)
            begin n_fail++; $display("FAIL br_flush got=f%b pc%0h r%b exp=f1 pc100 r0", bus.flush_out, bus.flush_pc_out, bus.disp_ready_out); end
        step();
        n_checks++; if (bus.flush_out !== 1'b0 || bus.commit_valid_out !== 1'b0 || bus.bp_update_out !== 1'b0 || count_out !== 4'd0 || bus.disp_id_out !== 4'd1)
            begin n_fail++; $display("FAIL br_after_flush got=f%b v%b u%b c%0d id%0d exp=f0 v0 u0 c0 id1", bus.flush_out, bus.commit_valid_out, bus.bp_update_out, count_out, bus.disp_id_out); end
        writeback(0, 4'd2, 32'h77, 32'h0, 1'b0);
        bus.q1_in = 4'd2;
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b0 || bus.q1_ready_out !== 1'b0)
            begin n_fail++; $display("FAIL br_discard got=v%b q1r%b exp=v0 q1r0", bus.commit_valid_out, bus.q1_ready_out); end
        bus.q1_in = '0;
        dispatch(5'd0, 32'h80, 32'h84, 1'b1, 1'b0, 1'b1);
        writeback(1, 4'd1, 32'h0, 32'h200, 1'b1);
        step();
        n_checks++; if (bus.bp_update_out !== 1'b1 || bus.bp_pc_out !== 32'h80 || bus.flush_out !== 1'b0)
            begin n_fail++; $display("FAIL br_correct got=u%b pc%0h f%b exp=u1 pc80 f0", bus.bp_update_out, bus.bp_pc_out, bus.flush_out); end
        dispatch(5'd0, 32'hc0, 32'hc4, 1'b1, 1'b0, 1'b1);
        writeback(0, 4'd2, 32'h0, 32'h300, 1'b0);
        step();
        n_checks++; if (bus.flush_out !== 1'b1 || bus.flush_pc_out !== 32'hc4 || bus.bp_taken_out !== 1'b0)
            begin n_fail++; $display("FAIL br_rollback got=f%b pc%0h t%b exp=f1 pcc4 t0", bus.flush_out, bus.flush_pc_out, bus.bp_taken_out); end
        step();
    endtask

    task automatic test_store_io();
        apply_reset();
        dispatch(5'd7, 32'h10, 32'h14, 1'b0, 1'b0, 1'b0);
        n_checks++; if (head_io_id_out !== 4'd0) begin n_fail++; $display("FAIL io_none got=%0d exp=0", head_io_id_out); end
        io_id_in = 4'd1;
        step();
        io_id_in = '0;
        n_checks++; if (head_io_id_out !== 4'd1) begin n_fail++; $display("FAIL io_head got=%0d exp=1", head_io_id_out); end
        dispatch(5'd0, 32'h14, 32'h18, 1'b0, 1'b1, 1'b0);
        writeback(0, 4'd1, 32'h99, 32'h0, 1'b0);
        n_checks++; if (bus.commit_valid_out !== 1'b0) begin n_fail++; $display("FAIL st_wait got=%b exp=0", bus.commit_valid_out); end
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b1 || bus.commit_id_out !== 4'd1 || bus.commit_is_store_out !== 1'b0 || head_io_id_out !== 4'd0)
            begin n_fail++; $display("FAIL st_alu_commit got=v%b id%0d s%b io%0d exp=v1 id1 s0 io0", bus.commit_valid_out, bus.commit_id_out, bus.commit_is_store_out, head_io_id_out); end
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b1 || bus.commit_id_out !== 4'd2 || bus.commit_is_store_out !== 1'b1 || count_out !== 4'd0)
            begin n_fail++; $display("FAIL st_commit got=v%b id%0d s%b c%0d exp=v1 id2 s1 c0", bus.commit_valid_out, bus.commit_id_out, bus.commit_is_store_out, count_out); end
    endtask

    task automatic test_bypass();
        apply_reset();
        for (int i = 0; i < 5; i++) dispatch(5'(i + 1), 32'(i * 4), 32'(i * 4 + 4), 1'b0, 1'b0, 1'b0);
        bus.q1_in = 4'd5; bus.q2_in = 4'd0;
        #1;
        n_checks++; if (bus.q1_ready_out !== 1'b0) begin n_fail++; $display("FAIL byp_not_ready got=%b exp=0", bus.q1_ready_out); end
        wb_set(0, 4'd5, 32'hbeef, 32'h0, 1'b0);
        wb_set(1, 4'd5, 32'hdead, 32'h0, 1'b0);
        #1;
        n_checks++; if (bus.q1_ready_out !== 1'b1 || bus.q1_data_out !== 32'hdead)
            begin n_fail++; $display("FAIL byp_priority got=r%b d%0h exp=r1 ddead", bus.q1_ready_out, bus.q1_data_out); end
        n_checks++; if (bus.q2_ready_out !== 1'b0 || bus.q2_data_out !== 32'h0)
            begin n_fail++; $display("FAIL byp_tag0 got=r%b d%0h exp=r0 d0", bus.q2_ready_out, bus.q2_data_out); end
        step();
        wb_clear();
        bus.q2_in = 4'd3;
        #1;
        n_checks++; if (bus.q1_ready_out !== 1'b1 || bus.q1_data_out !== 32'hdead || bus.q2_ready_out !== 1'b0)
            begin n_fail++; $display("FAIL byp_stored got=r%b d%0h q2r%b exp=r1 ddead q2r0", bus.q1_ready_out, bus.q1_data_out, bus.q2_ready_out); end
        wb_set(0, 4'd3, 32'h1234, 32'h0, 1'b0);
        #1;
        n_checks++; if (bus.q2_ready_out !== 1'b1 || bus.q2_data_out !== 32'h1234)
            begin n_fail++; $display("FAIL byp_ch0 got=r%b d%0h exp=r1 d1234", bus.q2_ready_out, bus.q2_data_out); end
        wb_clear();
        bus.q1_in = '0; bus.q2_in = '0;
    endtask

    task automatic test_freeze_reset();
        apply_reset();
        dispatch(5'd1, 32'h10, 32'h14, 1'b0, 1'b0, 1'b0);
        dispatch(5'd2, 32'h14, 32'h18, 1'b0, 1'b0, 1'b0);
        writeback(0, 4'd1, 32'ha1, 32'h0, 1'b0);
        rdy_in = 1'b0;
        bus.disp_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus.commit_valid_out !== 1'b0 || count_out !== 4'd2 || bus.disp_id_out !== 4'd3)
                begin n_fail++; $display("FAIL frz_hold%0d got=v%b c%0d id%0d exp=v0 c2 id3", i, bus.commit_valid_out, count_out, bus.disp_id_out); end
        end
        bus.disp_valid_in = 1'b0;
        rdy_in = 1'b1;
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b1 || bus.commit_id_out !== 4'd1 || bus.commit_data_out !== 32'ha1)
            begin n_fail++; $display("FAIL frz_resume got=v%b id%0d d%0h exp=v1 id1 da1", bus.commit_valid_out, bus.commit_id_out, bus.commit_data_out); end
        rdy_in = 1'b0;
        step();
        n_checks++; if (bus.commit_valid_out !== 1'b1 || bus.commit_id_out !== 4'd1 || count_out !== 4'd1)
            begin n_fail++; $display("FAIL frz_out_hold got=v%b id%0d c%0d exp=v1 id1 c1", bus.commit_valid_out, bus.commit_id_out, count_out); end
        rdy_in = 1'b1;
        #2 rst_in = 1'b0;
        #1;
        n_checks++; if (bus.commit_valid_out !== 1'b0 || bus.commit_id_out !== 4'd0 || bus.commit_data_out !== 32'h0 || count_out !== 4'd0 || bus.disp_id_out !== 4'd1)
            begin n_fail++; $display("FAIL async_reset got=v%b id%0d d%0h c%0d did%0d exp=v0 id0 d0 c0 did1", bus.commit_valid_out, bus.commit_id_out, bus.commit_data_out, count_out, bus.disp_id_out); end
        rst_in = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_branch();
        test_store_io();
        test_bypass();
        test_freeze_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
Parametrised re-order buffer: a circular queue of in-flight instructions between dispatcher, ALU/LSU writeback, register file, LSB, predictor and fetcher.
- Generalises the 16-entry, two-writeback-port buffer to DEPTH entries and NUM_WB writeback channels.
- Adds same-cycle writeback bypass on operand lookup, an explicit dispatch back-pressure handshake, and an occupancy counter wide enough to represent a full queue.
- Retires one instruction per cycle in order; on a branch mispredict it raises a registered flush.

Parameters:
DEPTH, 16, number of entries; power of two, >=4
NUM_WB, 2, number of writeback channels
XLEN, 32, data/pc width
IDW, $clog2(DEPTH)+1, tag width; tag 0 means "no producer / value ready", entry k has tag k+1

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  global enable; 0 freezes all state
disp_valid_in  in  1  dispatch request
disp_ready_out  out  1  comb: count<DEPTH and !flush_out
disp_id_out  out  IDW  comb: tail+1, tag given to the dispatched instruction
disp_rd_in  in  5  destination register
disp_pc_in / disp_rollback_pc_in  in  XLEN  instruction pc / fall-through pc
disp_is_branch_in, disp_is_store_in, disp_pred_taken_in  in  1 each  instruction class / prediction
q1_in, q2_in  in  IDW  operand tags to look up
q1_ready_out, q2_ready_out  out  1  comb: operand value available
q1_data_out, q2_data_out  out  XLEN  comb: operand value
wb_valid_in  in  NUM_WB  per-channel writeback strobe
wb_id_in  in  NUM_WB*IDW  packed tags
wb_data_in, wb_target_in  in  NUM_WB*XLEN  result / branch target
wb_taken_in  in  NUM_WB  branch resolved taken
io_id_in  in  IDW  LSB marks this tag as an IO access (0 = none)
head_io_id_out  out  IDW  comb: head+1 if head is busy and IO, else 0
commit_valid_out  out  1  registered one-cycle retire pulse
commit_id_out  out  IDW  tag of retired entry
commit_rd_out  out  5  destination register of retired entry
commit_data_out  out  XLEN  result of retired entry
commit_is_store_out  out  1  retired entry is a store (LSB releases it)
bp_update_out, bp_taken_out  out  1  predictor update strobe / actual direction
bp_pc_out  out  XLEN  pc of the resolved branch
flush_out  out  1  registered mispredict flush pulse
flush_pc_out  out  XLEN  redirect pc
count_out  out  IDW  occupancy 0..DEPTH

Behaviour:
- Reset (rst_in=0, asynchronous): head=tail=count=0; all busy/ready/flag bits 0; every registered output 0.
- rdy_in=0: no state changes, registered outputs hold their values.
- Dispatch: accepted iff disp_valid_in && disp_ready_out.
  - Writes entry[tail]: busy=1, ready=0, io=0, data=0; captures pc, rollback_pc, rd and flags.
  - tail wraps DEPTH-1 -> 0.
  - A request while full is dropped and state is unchanged.
  - disp_ready_out does not account for a commit in the same cycle.
- Writeback, per channel:
  - If wb_valid_in and tag!=0 and entry busy: set ready, data, target and taken.
  - Non-busy targets are ignored.
  - If two channels carry the same tag, the higher channel index wins.
- io_id_in!=0 and entry busy: set io=1.
- Commit condition (registered state only): busy[head] && (ready[head] || is_store[head]).
  - Next cycle: commit_valid_out=1 with the head entry's fields; head advances; the entry is cleared.
  - A writeback arriving in the same cycle affects commit no earlier than the following cycle.
- Branch commit:
  - bp_update_out=1, bp_pc_out=pc, bp_taken_out=taken.
  - If taken != predicted: flush_out=1, flush_pc_out = taken ? target : rollback_pc.
- Flush cycle (flush_out=1):
  - ROB clears all entries, head=tail=count=0.
  - Dispatch, writeback and commit are ignored; flush_out, commit_valid_out and bp_update_out return to 0.
  - Exactly one cycle long.
- count' = count + accepted_dispatch - commit; simultaneous dispatch and commit leaves count unchanged.
- Operand lookup, tag q:
  - q=0: ready=0, data=0.
  - Otherwise ready = ready[q-1] OR any wb_valid_in with matching tag.
  - data comes from the matching wb channel (highest index) if any, else data[q-1].
- Wrap-around: tags are stable for the entry's lifetime; reuse occurs only after commit or flush.

Decomposition:
- Shared package rob_pkg: tag-width function, TAG_NONE=0 constant, and the entry field layout (busy, ready, is_branch, is_store, io, pred, taken).
- Sub-module rob_wb_match: given a tag and the NUM_WB channel bundle, returns hit and data with highest-index priority.
  - Instantiated once per operand port.
  - Reused for the per-entry writeback update.

Test Plan:
- Reset, then dispatch 3 ALU ops with rd=1,2,3 -> disp_id_out 1,2,3; writeback tag2 then tag1 -> commits in order tag1, tag2; tag3 is held until written back; count returns to 0.
- Dispatch DEPTH entries with no writeback -> disp_ready_out=0, count_out=DEPTH; a further dispatch is dropped; a commit frees a slot and the next dispatch gets the wrapped tag.
- Branch predicted not-taken, writeback taken with target=0x100 -> bp_update_out=1, flush_out=1, flush_pc_out=0x100; next cycle count_out=0 and younger entries are discarded; a correctly predicted branch gives no flush.
- Store at head with no writeback -> commits the cycle after it reaches head with commit_is_store_out=1; io_id_in=head tag -> head_io_id_out equals head tag.
- q1_in=tag5 while wb channel 1 writes tag5 with data 0xDEAD and channel 0 writes tag5 with 0xBEEF -> q1_ready_out=1, q1_data_out=0xDEAD in the same cycle.
- rdy_in=0 for 3 cycles mid-stream -> no commits and no state change; rst_in pulsed low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
